icache_direct: RTL and testbench

ICACHE_DIRECT -- requirements
Module: icache_direct

---
 rtl/icache_direct.sv | 104 ++++++++++
 tb/tb_icache_direct.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per set.
// Hits are answered combinationally from IDLE. A miss latches its address and
// sits in FETCH until memory drops iwait; the word is then installed and the
// request is re-evaluated (and hits) from IDLE on the following cycle.
module icache_direct #(
  parameter int NSETS = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e                        state_q, state_d;
  logic [NSETS-1:0]              valid_q, valid_d;
  logic [NSETS-1:0][TAG_W-1:0]   tag_q;
  logic [NSETS-1:0][31:0]        data_q;
  // Word address of the outstanding miss; byte offset is never needed.
  logic [29:0]                   miss_q, miss_d;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             hit, fill;
  logic [1:0]       unused_boff;

  assign req_idx     = imemaddr[IDX_W+1:2];
  assign req_tag     = imemaddr[31:IDX_W+2];
  assign miss_idx    = miss_q[IDX_W-1:0];
  assign miss_tag    = miss_q[29:IDX_W];
  assign unused_boff = imemaddr[1:0];

  assign hit  = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
                (tag_q[req_idx] == req_tag);
  // A flush on the completion edge wins: the line is never marked valid.
  assign fill = (state_q == FETCH) && !iwait && !flush;

  // State, valid bits and miss address; reset abandons any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      valid_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
    end
  end

  // Next state: flush overrides everything, otherwise miss -> FETCH -> fill.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    miss_d  = miss_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (imemREN && !hit) begin
            state_d = FETCH;
            miss_d  = imemaddr[31:2];
          end
        end
        FETCH: begin
          if (!iwait) begin
            state_d           = IDLE;
            valid_d[miss_idx] = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: hit data only from IDLE, memory request only from FETCH.
  always_comb begin
    ihit     = hit && !flush;
    imemload = ihit ? data_q[req_idx] : 32'h0;
    iREN     = (state_q == FETCH);
    iaddr    = (state_q == FETCH) ? {miss_q, 2'b00} : 32'h0;
  end

  // Tag/data storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against an address-level model
// (each set remembers which word address it holds; one pending miss at most).
module tb_icache_direct;
  localparam int NSETS = 16;
  localparam int IDX_W = 4;

  logic        CLK, nRST;
  logic        imemREN, flush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  icache_direct #(.NSETS(NSETS), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .flush(flush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backing memory contents as a function of word address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h40) return 32'h8C220004;
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign iload = iwait ? 32'hBAD0BAD0 : mem(iaddr);

  // ---------------- reference model ----------------
  bit          m_valid [NSETS];
  logic [31:0] m_word  [NSETS];
  bit          m_busy;
  logic [31:0] m_pend;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % NSETS);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s;
    s = set_of(a);
    return !m_busy && imemREN && !flush && m_valid[s] &&
           (m_word[s] == {a[31:2], 2'b00});
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0;
      m_pend = 32'h0;
    end else if (flush) begin
      for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (imemREN && !m_hit(imemaddr)) begin
        m_busy = 1'b1;
        m_pend = {imemaddr[31:2], 2'b00};
      end
    end else if (!iwait) begin
      m_valid[set_of(m_pend)] = 1'b1;
      m_word[set_of(m_pend)]  = m_pend;
      m_busy = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge CLK) begin : cmp
    bit h;
    h = m_hit(imemaddr);
    chk("m_ihit",     {31'd0, ihit},  {31'd0, h});
    chk("m_imemload", imemload,       h ? mem(imemaddr) : 32'h0);
    chk("m_iREN",     {31'd0, iREN},  {31'd0, m_busy});
    chk("m_iaddr",    iaddr,          m_busy ? m_pend : 32'h0);
  end

  // One clock of stimulus; returns with outputs settled for that cycle.
  task automatic cyc(input bit r, input logic [31:0] a, input bit f, input bit w);
    @(posedge CLK);
    #1;
    imemREN = r; imemaddr = a; flush = f; iwait = w;
    #2;
  endtask

  task automatic fill(input logic [31:0] a);
    cyc(1, a, 0, 1);
    chk("fill_miss", {31'd0, ihit}, 32'd0);
    cyc(1, a, 0, 0);
    chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
  endtask

  initial begin
    logic [31:0] a;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1;
    #12;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iREN", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_load", imemload, 32'h0);
    nRST = 1'b1;

    // Cold miss with three wait cycles.
    cyc(1, 32'h40, 0, 1);
    chk("cold_ihit", {31'd0, ihit}, 32'd0);
    chk("cold_iREN0", {31'd0, iREN}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h40, 0, (i < 3));
      chk("cold_iREN", {31'd0, iREN}, 32'd1);
      chk("cold_iaddr", iaddr, 32'h40);
      chk("cold_noihit", {31'd0, ihit}, 32'd0);
    end
    cyc(1, 32'h40, 0, 1);
    chk("cold_hit", {31'd0, ihit}, 32'd1);
    chk("cold_data", imemload, 32'h8C220004);
    // Repeat hit, byte offset ignored.
    cyc(1, 32'h43, 0, 1);
    chk("rep_hit", {31'd0, ihit}, 32'd1);
    chk("rep_iREN", {31'd0, iREN}, 32'd0);
    // Idle request line low.
    cyc(0, 32'h40, 0, 1);
    chk("idle_noihit", {31'd0, ihit}, 32'd0);
    chk("idle_load0", imemload, 32'h0);

    // Conflict eviction in set 0.
    fill(32'h440);
    cyc(1, 32'h440, 0, 1);
    chk("conf_hit", {31'd0, ihit}, 32'd1);
    cyc(1, 32'h40, 0, 1);
    chk("conf_evict", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h40, 0, 0);

    // Redirect while waiting.
    cyc(1, 32'h80, 0, 1);
    cyc(1, 32'h100, 0, 1);
    chk("redir_hold", iaddr, 32'h80);
    cyc(1, 32'h100, 0, 0);
    chk("redir_fill", iaddr, 32'h80);
    cyc(1, 32'h80, 0, 1);
    chk("redir_hit80", {31'd0, ihit}, 32'd1);
    cyc(1, 32'h100, 0, 1);
    chk("redir_miss100", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h100, 0, 0);
    chk("redir_iaddr100", iaddr, 32'h100);

    // Flush of sets 0..3, then flush coincident with fill completion.
    for (int i = 0; i < 4; i++) fill(32'(i * 4));
    cyc(1, 32'h4, 0, 1);
    chk("pre_flush_hit", {31'd0, ihit}, 32'd1);
    cyc(1, 32'h4, 1, 1);
    chk("flush_noihit", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h8, 0, 1);
    chk("post_flush_miss", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h8, 1, 0);
    chk("flush_fill_iREN", {31'd0, iREN}, 32'd1);
    cyc(1, 32'h8, 0, 1);
    chk("flush_wins", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h8, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        cyc(1, 32'(i * 4), 0, 1);
        chk("flushed_miss", {31'd0, ihit}, 32'd0);
        cyc(1, 32'(i * 4), 0, 0);
      end
    end

    // Reset in the middle of a fill.
    fill(32'h40);
    cyc(1, 32'h440, 0, 1);
    cyc(1, 32'h440, 0, 1);
    chk("rmid_iREN1", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rmid_iREN0", {31'd0, iREN}, 32'd0);
    chk("rmid_iaddr0", iaddr, 32'h0);
    chk("rmid_ihit0", {31'd0, ihit}, 32'd0);
    @(posedge CLK);
    #2 nRST = 1'b1;
    cyc(1, 32'h440, 0, 1);
    chk("rmid_miss", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h440, 0, 0);
    cyc(1, 32'h40, 0, 1);
    chk("rmid_miss40", {31'd0, ihit}, 32'd0);
    cyc(1, 32'h40, 0, 0);

    // Randomized traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) |
               32'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) != 0);
    end

    @(posedge CLK);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
